sign_mag_accumulator: RTL and testbench



---
 rtl/sign_mag_accumulator.sv | 155 +++++++++++++++
 tb/tb_sign_mag_accumulator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sign_mag_accumulator.sv
// rtl/sign_mag_accumulator.sv - frame accumulator for sign-magnitude samples
//
// Accumulates FRAME accepted sign-magnitude samples into a wider
// sign-magnitude register, then offers the frame total on an output
// handshake. Same-sign carries saturate the magnitude and set a sticky ovf.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   clear     synchronous frame abort (beats accept and out_ready)
//   in_valid  sample valid
//   in_ready  block can accept (1 in IDLE/ACCUM, 0 in DONE; state only)
//   in_data   N-bit sign-magnitude sample
//   out_valid frame total available
//   out_ready consumer takes the frame total
//   out_data  ACC_W-bit sign-magnitude running/frame total (registered)
//   ovf       saturation occurred during this frame

module sign_mag_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int FRAME = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf
);

  localparam int MW    = ACC_W - 1;
  localparam int CNT_W = $clog2(FRAME + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [MW-1:0]    in_mag;
  logic             in_sign;
  logic [MW-1:0]    acc_mag;
  logic             acc_sign;
  logic [MW:0]      sum_ext;
  logic [MW-1:0]    add_mag;
  logic             add_sign;
  logic             add_ovf;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign ovf       = ovf_q;
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // A -0 input collapses to +0 so it can never flip the accumulator sign.
  assign in_mag   = {{(ACC_W - N){1'b0}}, in_data[N-2:0]};
  assign in_sign  = in_data[N-1] & (|in_data[N-2:0]);
  assign acc_mag  = acc_q[MW-1:0];
  assign acc_sign = acc_q[ACC_W-1];
  assign sum_ext  = {1'b0, acc_mag} + {1'b0, in_mag};

  // Sign-magnitude add, larger magnitude decides the sign.
  always_comb begin
    add_mag  = '0;
    add_sign = 1'b0;
    add_ovf  = 1'b0;
    if (acc_sign == in_sign) begin
      add_sign = acc_sign;
      if (sum_ext[MW]) begin
        add_mag = '1;
        add_ovf = 1'b1;
      end else begin
        add_mag = sum_ext[MW-1:0];
      end
    end else if (acc_mag >= in_mag) begin
      add_mag  = acc_mag - in_mag;
      add_sign = acc_sign;
    end else begin
      add_mag  = in_mag - acc_mag;
      add_sign = in_sign;
    end
    if (add_mag == '0) begin
      add_sign = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d = {add_sign, add_mag};
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_ovf;
            if (cnt_inc == CNT_W'(FRAME)) begin
              state_d = DONE;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sign_mag_accumulator.sv
// tb/tb_sign_mag_accumulator.sv - directed self-checking bench for sign_mag_accumulator

module tb_sign_mag_accumulator;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic       in_ready, out_valid, ovf;
  logic [7:0] out_data;
  logic       in_ready5, out_valid5, ovf5;
  logic [4:0] out_data5;

  int n_vec;
  int n_err;

  sign_mag_accumulator #(.N(4), .ACC_W(8), .FRAME(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ovf(ovf)
  );

  sign_mag_accumulator #(.N(4), .ACC_W(5), .FRAME(4)) dut5 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data),
    .out_valid(out_valid5), .out_ready(out_ready),
    .out_data(out_data5), .ovf(ovf5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] data;
    logic       ordy;
    logic [7:0] exp_data;
    logic       exp_ovf;
    logic       exp_valid;
    logic       exp_rdy;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] d, input logic o,
                        input logic v, input logic r);
    check({tag, ".out_data"}, 32'(out_data), 32'(d));
    check({tag, ".ovf"}, 32'(ovf), 32'(o));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(r));
  endtask

  task automatic push(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // frame A: +4 -7 +7 -4 -> 0; then handoff while a DONE-cycle sample is ignored
    tbl[0]  = '{1'b1, 4'b0100, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 8'h83, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 4'b0111, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 4'b1100, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'b0111, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    // frame B: -4 -2 -7 -7 -> -20
    tbl[5]  = '{1'b1, 4'b1100, 1'b1, 8'h84, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 4'b1010, 1'b1, 8'h86, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 4'b1111, 1'b1, 8'h8D, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'b1111, 1'b1, 8'h94, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    // frame C: +3 -3 -0 +0 -> never -0
    tbl[10] = '{1'b1, 4'b0011, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 4'b1011, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 4'b1000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 4'b0000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

    #13;
    check8("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 15; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].data;
      out_ready = tbl[i].ordy;
      cyc();
      check8($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_ovf,
             tbl[i].exp_valid, tbl[i].exp_rdy);
    end
    in_valid = 1'b0;

    // saturation on the 5-bit accumulator: 7, 14, sat 15 (ovf), 13
    out_ready = 1'b0;
    push(4'b0111);
    check("sat.d1", 32'(out_data5), 32'h07); check("sat.o1", 32'(ovf5), 0);
    push(4'b0111);
    check("sat.d2", 32'(out_data5), 32'h0E); check("sat.o2", 32'(ovf5), 0);
    push(4'b0111);
    check("sat.d3", 32'(out_data5), 32'h0F); check("sat.o3", 32'(ovf5), 1);
    push(4'b1010);
    check("sat.d4", 32'(out_data5), 32'h0D); check("sat.o4", 32'(ovf5), 1);
    check("sat.v4", 32'(out_valid5), 1);
    check("sat.wide", 32'(out_data), 32'h13);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("sat.ovf_after", 32'(ovf5), 0);
    check("sat.d_after", 32'(out_data5), 0);

    // backpressure in DONE: samples must not be absorbed
    push(4'b0001); push(4'b0010); push(4'b0011); push(4'b0001);
    check8("bp.done", 8'h07, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 3);
      cyc();
      check8($sformatf("bp.hold%0d", i), 8'h07, 1'b0, 1'b1, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check8("bp.handoff", 8'h00, 1'b0, 1'b0, 1'b1);
    push(4'b0001); push(4'b0001); push(4'b0001);
    check8("bp.next3", 8'h03, 1'b0, 1'b0, 1'b1);
    push(4'b0001);
    check8("bp.next4", 8'h04, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // clear mid-frame drops the coincident sample and restarts the count
    push(4'b0101); push(4'b0001);
    check8("clr.pre", 8'h06, 1'b0, 1'b0, 1'b1);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'b0111;
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    check8("clr.post", 8'h00, 1'b0, 1'b0, 1'b1);
    push(4'b0001); push(4'b0010);
    check8("clr.f2", 8'h03, 1'b0, 1'b0, 1'b1);
    push(4'b0011);
    check8("clr.f3", 8'h06, 1'b0, 1'b0, 1'b1);
    push(4'b0100);
    check8("clr.f4", 8'h0A, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // asynchronous reset between edges with ovf set
    push(4'b0111); push(4'b0111); push(4'b0111);
    check("rst.pre_ovf5", 32'(ovf5), 1);
    #2;
    rst = 1'b1;
    #1;
    check8("rst.async", 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst.ovf5", 32'(ovf5), 0);
    check("rst.d5", 32'(out_data5), 0);
    cyc();
    rst = 1'b0;
    push(4'b0010);
    check8("rst.restart", 8'h02, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
